// File: rtl/sha256_job_ctrl_if.sv
// sha256_job_ctrl_if: host, stage and output-SRAM signals of the SHA256 job controller
interface sha256_job_ctrl_if #(
  parameter int MAX_MESSAGE_LENGTH = 55,
  parameter int OUTPUT_LENGTH = 8,
  parameter int CNT_WIDTH = 16
);
  localparam int LW = $clog2(MAX_MESSAGE_LENGTH);
  localparam int AW = $clog2(OUTPUT_LENGTH);
  logic start, err_clr, busy, done, error;
  logic [LW-1:0] msg_len_in, msg_len_out;
  logic [1:0] err_code;
  logic [CNT_WIDTH-1:0] job_count;
  logic pad_go, pad_rdy, w_go, w_rdy, h_go, h_finish;
  logic h_op_en;
  logic [AW-1:0] h_op_addr;
  logic [31:0] h_op_wdata;
  logic rd_req, rd_grant;
  logic [AW-1:0] rd_addr;
  logic op_mem_en, op_mem_write;
  logic [AW-1:0] op_mem_addr;
  logic [31:0] op_mem_wdata;
  modport master (
    output start, msg_len_in, err_clr, pad_rdy, w_rdy, h_finish, h_op_en, h_op_addr, h_op_wdata, rd_req, rd_addr,
    input busy, done, error, err_code, job_count, msg_len_out, pad_go, w_go, h_go, rd_grant,
    input op_mem_en, op_mem_write, op_mem_addr, op_mem_wdata
  );
  modport slave (
    input start, msg_len_in, err_clr, pad_rdy, w_rdy, h_finish, h_op_en, h_op_addr, h_op_wdata, rd_req, rd_addr,
    output busy, done, error, err_code, job_count, msg_len_out, pad_go, w_go, h_go, rd_grant,
    output op_mem_en, op_mem_write, op_mem_addr, op_mem_wdata
  );
endinterface

// File: rtl/sha256_job_ctrl.sv
// sha256_job_ctrl: sequences one SHA256 block job through pad, W-expansion and compression with a per-stage watchdog
module sha256_job_ctrl #(
  parameter int MAX_MESSAGE_LENGTH = 55,
  parameter int OUTPUT_LENGTH = 8,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_WIDTH = 16
) (
  input logic clock,
  input logic reset,
  sha256_job_ctrl_if.slave bus
);
  localparam int LW = $clog2(MAX_MESSAGE_LENGTH);
  localparam int AW = $clog2(OUTPUT_LENGTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [2:0] {IDLE, PAD, WEXP, HCOMP, DONE, ERR} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] wd_q, wd_d;
  logic [1:0] err_code_q, err_code_d;
  logic [CNT_WIDTH-1:0] job_count_q, job_count_d;
  logic [LW-1:0] msg_len_q, msg_len_d;
  logic pad_go_q, w_go_q, h_go_q;
  logic len_ok, staged, awaited, h_own;
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      wd_q <= '0;
      err_code_q <= '0;
      job_count_q <= '0;
      msg_len_q <= '0;
      pad_go_q <= 1'b0;
      w_go_q <= 1'b0;
      h_go_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q <= wd_d;
      err_code_q <= err_code_d;
      job_count_q <= job_count_d;
      msg_len_q <= msg_len_d;
      pad_go_q <= state_d == PAD && state_q != PAD;
      w_go_q <= state_d == WEXP && state_q != WEXP;
      h_go_q <= state_d == HCOMP && state_q != HCOMP;
    end
  end
  always_comb begin
    len_ok = bus.msg_len_in != '0 && 32'(bus.msg_len_in) <= MAX_MESSAGE_LENGTH;
    staged = state_q inside {PAD, WEXP, HCOMP};
    awaited = state_q == PAD ? bus.pad_rdy : state_q == WEXP ? bus.w_rdy : state_q == HCOMP && bus.h_finish;
    state_d = state_q;
    err_code_d = err_code_q;
    msg_len_d = msg_len_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = len_ok ? PAD : ERR;
        msg_len_d = len_ok ? bus.msg_len_in : msg_len_q;
        err_code_d = len_ok ? 2'd0 : 2'd1;
      end
      PAD, WEXP, HCOMP: if (awaited) begin
        state_d = state_q == PAD ? WEXP : state_q == WEXP ? HCOMP : DONE;
      end else if (wd_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d = ERR;
        err_code_d = 2'd2;
      end
      DONE: state_d = IDLE;
      ERR: if (bus.err_clr) begin
        state_d = IDLE;
        err_code_d = 2'd0;
      end
      default: state_d = IDLE;
    endcase
    // watchdog restarts from zero on every state entry
    wd_d = (staged && state_d == state_q) ? wd_q + TW'(1) : '0;
    job_count_d = job_count_q + CNT_WIDTH'(state_d == DONE && state_q != DONE);
  end
  assign h_own = state_q == HCOMP;
  assign bus.busy = state_q inside {PAD, WEXP, HCOMP, DONE};
  assign bus.done = state_q == DONE;
  assign bus.error = state_q == ERR;
  assign bus.err_code = err_code_q;
  assign bus.job_count = job_count_q;
  assign bus.msg_len_out = msg_len_q;
  assign bus.pad_go = pad_go_q;
  assign bus.w_go = w_go_q;
  assign bus.h_go = h_go_q;
  // compression owns the SRAM port during HCOMP; host reads are dropped, not queued
  assign bus.op_mem_en = h_own ? bus.h_op_en : bus.rd_req;
  assign bus.op_mem_write = h_own;
  assign bus.op_mem_addr = AW'(h_own ? bus.h_op_addr : bus.rd_addr);
  assign bus.op_mem_wdata = h_own ? bus.h_op_wdata : '0;
  assign bus.rd_grant = !h_own && bus.rd_req;
endmodule
